// File: rtl/s_machine_pkg.sv
// Shared types and widths for the fetch stage and its interpreter.
package s_machine_pkg;
   localparam int ADDR_W = 8;
   localparam int INST_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC_DEF = 8'h00;

   typedef enum logic [1:0] {IDLE, FETCH, FLUSH} fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small in-order synchronous FIFO, used both for the prefetch buffer and
// for the queue of addresses still waiting on a memory response.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 24,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          clear_i,
   input  logic [W-1:0]  din_i,
   output logic [W-1:0]  dout_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rptr_q];
   assign do_push = push_i && !full_o && !clear_i;
   assign do_pop  = pop_i && !empty_o && !clear_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wptr_q] <= din_i;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && full_o && !clear_i));
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: credit-limited prefetch from program memory into an
// in-order buffer, with redirect flush that drops in-flight responses.
module inst_fetch_unit
   import s_machine_pkg::*;
#(
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = $bits(fetch_entry_t);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, tag_pc;
   logic [CW-1:0]     out_q, out_d, drop_q, drop_d, out_after, buf_cnt, tag_cnt;
   logic              flush, rsp, drop, push, pop, issue;
   logic              buf_full, buf_empty, tag_full, tag_empty;
   logic [EW-1:0]     buf_din, buf_dout;
   fetch_entry_t      push_ent, head;

   assign flush     = redirect && (state_q != IDLE);
   // Responses with nothing outstanding (stale after a reset) are ignored.
   assign rsp       = imem_rvalid && (out_q != '0);
   assign drop      = rsp && (drop_q != '0);
   assign push      = rsp && !drop && !flush;
   assign pop       = inst_valid && inst_ready;
   assign out_after = out_q - CW'(rsp);

   // The slot freed by this cycle's pop counts as credit, so a latency-1
   // memory sustains one instruction per cycle with only DEPTH entries.
   assign issue = (state_q == FETCH) && !redirect &&
                  ((CW+1)'(buf_cnt) + (CW+1)'(out_q) - (CW+1)'(pop) < (CW+1)'(DEPTH));

   assign out_d  = out_q + CW'(issue) - CW'(rsp);
   assign drop_d = flush ? out_after : drop_q - CW'(drop);
   assign pc_d   = flush ? redirect_pc : (issue ? pc_q + 1'b1 : pc_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   if (flush && (out_after != '0)) state_d = FLUSH;
         FLUSH:   if (drop_d == '0) state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         out_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
      end
   end

   assign imem_req  = issue;
   assign imem_addr = issue ? pc_q : '0;

   fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W)) u_tag (
      .clk(clk), .rst_n(rst_n),
      .push_i(issue), .pop_i(rsp), .clear_i(1'b0),
      .din_i(pc_q), .dout_o(tag_pc), .count_o(tag_cnt),
      .full_o(tag_full), .empty_o(tag_empty)
   );

   assign push_ent = '{pc: tag_pc, inst: imem_rdata};
   assign buf_din  = push_ent;
   assign head     = buf_dout;

   fetch_fifo #(.DEPTH(DEPTH), .W(EW)) u_buf (
      .clk(clk), .rst_n(rst_n),
      .push_i(push), .pop_i(pop), .clear_i(flush),
      .din_i(buf_din), .dout_o(buf_dout), .count_o(buf_cnt),
      .full_o(buf_full), .empty_o(buf_empty)
   );

   assign inst_valid = !buf_empty;
   assign inst       = buf_empty ? '0 : head.inst;
   assign inst_pc    = buf_empty ? '0 : head.pc;

   a_credit: assert property (@(posedge clk) disable iff (!rst_n)
      (tag_cnt == out_q) && !(push && buf_full) && !(rsp && tag_empty) && !(issue && tag_full));
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench: memory model returns 16'hA000|addr; a scoreboard queue
// holds the instructions each DUT is expected to hand over, in order.
module tb_inst_fetch_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, redirect, inst_ready;
   logic [7:0]  redirect_pc;
   logic        imem_req, imem_rvalid, inst_valid;
   logic [7:0]  imem_addr, inst_pc;
   logic [15:0] imem_rdata, inst;
   logic [1:0]  lsel;

   logic        w_ready, w_req, w_rvalid, w_valid;
   logic [7:0]  w_addr, w_pc;
   logic [15:0] w_rdata, w_inst;

   inst_fetch_unit #(.DEPTH(2), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc)
   );

   inst_fetch_unit #(.DEPTH(2), .RESET_PC(8'hFE)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .redirect(1'b0), .redirect_pc(8'h00),
      .imem_req(w_req), .imem_addr(w_addr), .imem_rvalid(w_rvalid),
      .imem_rdata(w_rdata), .inst_valid(w_valid), .inst_ready(w_ready),
      .inst(w_inst), .inst_pc(w_pc)
   );

   // Program memory with selectable latency 1..4 (lsel = latency-1).
   logic [3:0] rv_p;
   logic [7:0] ra_p [4];
   logic       w_rv_q;
   logic [7:0] w_ra_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rv_p   <= '0;
         w_rv_q <= 1'b0;
         w_ra_q <= '0;
         for (int i = 0; i < 4; i++) ra_p[i] <= '0;
      end else begin
         rv_p    <= {rv_p[2:0], imem_req};
         ra_p[0] <= imem_addr;
         for (int i = 1; i < 4; i++) ra_p[i] <= ra_p[i-1];
         w_rv_q  <= w_req;
         w_ra_q  <= w_addr;
      end
   end
   assign imem_rvalid = rv_p[lsel];
   assign imem_rdata  = 16'hA000 | {8'h00, ra_p[lsel]};
   assign w_rvalid    = w_rv_q;
   assign w_rdata     = 16'hA000 | {8'h00, w_ra_q};

   typedef struct {
      logic [7:0]  pc;
      logic [15:0] ins;
   } exp_t;
   exp_t q[$];
   exp_t wq[$];
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_seq(input logic [7:0] start, input int n, input bit wrap_dut);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc  = start + 8'(i);
         e.ins = 16'hA000 | {8'h00, e.pc};
         if (wrap_dut) wq.push_back(e);
         else q.push_back(e);
      end
   endtask

   task automatic sample();
      exp_t e;
      if (inst_valid && inst_ready) begin
         chk("pop_expected", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("inst_pc", {24'h0, inst_pc}, {24'h0, e.pc});
            chk("inst", {16'h0, inst}, {16'h0, e.ins});
         end
      end
      if (w_valid && w_ready) begin
         chk("wrap_pop_expected", 32'(wq.size() > 0), 32'd1);
         if (wq.size() > 0) begin
            e = wq.pop_front();
            chk("wrap_inst_pc", {24'h0, w_pc}, {24'h0, e.pc});
            chk("wrap_inst", {16'h0, w_inst}, {16'h0, e.ins});
         end
      end
   endtask

   task automatic cyc();
      #1;
      sample();
      @(negedge clk);
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while ((q.size() > 0 || wq.size() > 0) && n < bound) begin
         cyc();
         n++;
      end
      chk("drain_left", q.size() + wq.size(), 0);
   endtask

   task automatic do_reset(input logic [1:0] ls);
      @(negedge clk);
      rst_n = 1'b0;
      lsel  = ls;
      q.delete();
      wq.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit found;
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
      inst_ready = 1'b0; w_ready = 1'b0; lsel = 2'd0;
      #2;
      chk("rst_req", {31'h0, imem_req}, 0);
      chk("rst_addr", {24'h0, imem_addr}, 0);
      chk("rst_valid", {31'h0, inst_valid}, 0);
      chk("rst_inst", {16'h0, inst}, 0);
      chk("rst_pc", {24'h0, inst_pc}, 0);

      // Reset release: idle one cycle, then the first request to RESET_PC.
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("idle_req", {31'h0, imem_req}, 0);
      @(negedge clk);
      #1 chk("first_req", {31'h0, imem_req}, 1);
      chk("first_addr", {24'h0, imem_addr}, 32'h00);
      @(negedge clk);

      // Backpressure: buffer fills to DEPTH and requests stop.
      repeat (5) cyc();
      #1;
      chk("bp_valid", {31'h0, inst_valid}, 1);
      chk("bp_inst", {16'h0, inst}, 32'hA000);
      chk("bp_pc", {24'h0, inst_pc}, 32'h00);
      chk("bp_req", {31'h0, imem_req}, 0);
      @(negedge clk);

      // Release: ten words in ten cycles, in order.
      expect_seq(8'h00, 10, 1'b0);
      inst_ready = 1'b1;
      repeat (10) cyc();
      chk("throughput_left", q.size(), 0);
      inst_ready = 1'b0;
      repeat (3) cyc();

      // Reset mid-stream with a full buffer: outputs clear immediately.
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'h0, inst_valid}, 0);
      chk("mid_rst_inst", {16'h0, inst}, 0);
      chk("mid_rst_pc", {24'h0, inst_pc}, 0);
      chk("mid_rst_req", {31'h0, imem_req}, 0);
      chk("mid_rst_addr", {24'h0, imem_addr}, 0);

      // Redirect with two requests outstanding at latency 3.
      do_reset(2'd2);
      repeat (3) cyc();
      #1 chk("credit_req", {31'h0, imem_req}, 0);
      redirect = 1'b1; redirect_pc = 8'h40;
      cyc();
      redirect = 1'b0;
      #1;
      chk("flush_valid", {31'h0, inst_valid}, 0);
      chk("flush_req", {31'h0, imem_req}, 0);
      expect_seq(8'h40, 4, 1'b0);
      inst_ready = 1'b1;
      @(negedge clk);
      drain(40);
      inst_ready = 1'b0;

      // PC wrap on the RESET_PC=FE instance.
      do_reset(2'd0);
      expect_seq(8'hFE, 4, 1'b1);
      w_ready = 1'b1;
      drain(40);
      w_ready = 1'b0;

      // Redirect on a handshake, then again while flushing.
      do_reset(2'd2);
      expect_seq(8'h00, 2, 1'b0);
      inst_ready = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 30 && !found; n++) begin
         #1;
         if (inst_valid && inst_pc === 8'h01) found = 1'b1;
         else begin
            sample();
            @(negedge clk);
         end
      end
      chk("wait_pc01", {31'h0, found}, 1);
      redirect = 1'b1; redirect_pc = 8'h10;
      cyc();
      chk("hs_consumed", q.size(), 0);
      redirect_pc = 8'h20;
      #1;
      chk("flush2_valid", {31'h0, inst_valid}, 0);
      chk("flush2_req", {31'h0, imem_req}, 0);
      @(negedge clk);
      redirect = 1'b0;
      expect_seq(8'h20, 4, 1'b0);
      drain(40);
      inst_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
